// File: rtl/ob_ram_rd_stream_if.sv
// Command, RAM-read and output-stream signals of the outbound RAM drain stage.
// master = the drain stage itself, slave = its surroundings (command source, RAM array, sink).
interface ob_ram_rd_stream_if #(
    parameter int LEN_W = 12
);
    logic             CmdValid;
    logic             CmdReady;
    logic [31:0]      CmdAddr;
    logic [LEN_W-1:0] CmdLen;
    logic             RdEn;
    logic [31:0]      RdAddr;
    logic [127:0]     RdData;
    logic             OutValid;
    logic             OutReady;
    logic [127:0]     OutData;
    logic             OutLast;
    logic             Busy;
    logic             Done;
    logic             CmdErr;

    modport master (
        input  CmdValid, CmdAddr, CmdLen, RdData, OutReady,
        output CmdReady, RdEn, RdAddr, OutValid, OutData, OutLast, Busy, Done, CmdErr
    );

    modport slave (
        output CmdValid, CmdAddr, CmdLen, RdData, OutReady,
        input  CmdReady, RdEn, RdAddr, OutValid, OutData, OutLast, Busy, Done, CmdErr
    );
endinterface

// File: rtl/ob_ram_rd_stream.sv
// Drains a word range of the 8-bank outbound RAM onto a valid/ready stream; OB_RD_RANGE_CHK_EN adds command range checking.
// Latency accept->RdEn 1, ->OutValid RD_LAT+2; OutReady low stalls reads through FIFO credits, data is never dropped.
module ob_ram_rd_stream #(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    ob_ram_rd_stream_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t           state, nextState;
    logic [10:0]      curAddr;
    logic [LEN_W-1:0] remLen;
    logic [RD_LAT-1:0] vldSh, lastSh;
    logic [128:0]     fifoMem [FIFO_DEPTH];
    logic [PW-1:0]    wrPtr, rdPtr;
    logic [CW-1:0]    count, inflight;
    logic             accept, cmdBad, issue, issueLast, credit, push, pop;
    logic             doneQ, errQ;

    assign accept = bus.CmdValid && bus.CmdReady;

`ifdef OB_RD_RANGE_CHK_EN
    assign cmdBad = (bus.CmdAddr[31:11] != '0) ||
                    ((32'(bus.CmdAddr[10:0]) + 32'(bus.CmdLen)) > 32'd2048);
`else
    logic unusedAddrHi;
    assign unusedAddrHi = ^bus.CmdAddr[31:11];
    assign cmdBad       = 1'b0;
`endif

    // Reads already issued but not yet written to the FIFO still hold a credit.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(vldSh[i]);
        end
    end

    assign credit    = (count + inflight) < CW'(FIFO_DEPTH);
    assign issueLast = issue && (remLen == LEN_W'(1));
    assign push      = vldSh[RD_LAT-1];
    assign pop       = bus.OutValid && bus.OutReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        issue        = 1'b0;
        bus.CmdReady = 1'b0;
        case (state)
            IDLE: begin
                bus.CmdReady = rst_n;
                if (bus.CmdValid && rst_n && !cmdBad && (bus.CmdLen != '0)) begin
                    nextState = READ;
                end
            end
            READ: begin
                issue = credit;
                if (credit && (remLen == LEN_W'(1))) begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && bus.OutLast) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curAddr <= '0;
            remLen  <= '0;
            vldSh   <= '0;
            lastSh  <= '0;
            doneQ   <= 1'b0;
            errQ    <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            errQ  <= 1'b0;
            if (accept) begin
                curAddr <= bus.CmdAddr[10:0];
                remLen  <= bus.CmdLen;
                if (cmdBad) begin
                    errQ <= 1'b1;
                end else if (bus.CmdLen == '0) begin
                    doneQ <= 1'b1;
                end
            end else if (issue) begin
                curAddr <= curAddr + 11'd1;
                remLen  <= remLen - 1'b1;
            end
            if ((state == DRAIN) && (nextState == IDLE)) begin
                doneQ <= 1'b1;
            end
            vldSh[0]  <= issue;
            lastSh[0] <= issueLast;
            for (int i = 1; i < RD_LAT; i++) begin
                vldSh[i]  <= vldSh[i-1];
                lastSh[i] <= lastSh[i-1];
            end
        end
    end

    // Output FIFO; the head entry drives the stream directly from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifoMem[wrPtr] <= {lastSh[RD_LAT-1], bus.RdData};
                wrPtr          <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign bus.OutValid             = (count != '0);
    assign {bus.OutLast, bus.OutData} = fifoMem[rdPtr];
    assign bus.RdEn                 = issue;
    assign bus.RdAddr               = {21'b0, curAddr};
    assign bus.Busy                 = (state != IDLE);
    assign bus.Done                 = doneQ;
    assign bus.CmdErr               = errQ;
endmodule
